// File: rtl/cntdown_timer_pkg.sv
// Shared definitions for the mm:ss countdown timer: FSM encoding, field limits
// and the load-value saturation helper.
package cntdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int MAX_SEC_DEF = 59;
    localparam int MAX_MIN_DEF = 59;

    function automatic logic [5:0] sat6(input logic [5:0] v, input logic [5:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/cntdown_tick.sv
// Prescaler: counts enabled cycles 0..num-1 and strobes tick on the last one.
// num of 0 or 1 gives a tick on every enabled cycle.
module cntdown_tick (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] num,
    output logic        tick
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [31:0] limit;

    // >= rather than == so a period shortened mid-run fires on the next cycle
    always_comb begin
        limit = (num > 32'd1) ? (num - 32'd1) : 32'd0;
        tick  = en && !clr && (cnt_q >= limit);
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = 32'd0;
        end else if (en) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cntdown_timer.sv
// Loadable mm:ss countdown timer with built-in prescaler and one-cycle done pulse.
// Define AUTO_RELOAD_EN to restart from the saved load value instead of stopping at 00:00.
module cntdown_timer
    import cntdown_timer_pkg::*;
#(
    parameter int MAX_SEC = MAX_SEC_DEF,
    parameter int MAX_MIN = MAX_MIN_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] num,
    input  logic        load,
    input  logic [5:0]  load_min,
    input  logic [5:0]  load_sec,
    input  logic        start,
    input  logic        pause,
    output logic [5:0]  min,
    output logic [5:0]  sec,
    output logic        running,
    output logic        done
);

    localparam logic [5:0] SEC_MAX = 6'(MAX_SEC);
    localparam logic [5:0] MIN_MAX = 6'(MAX_MIN);

    state_e     state_q, state_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] saved_min_q, saved_min_d;
    logic [5:0] saved_sec_q, saved_sec_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       start_idle;
    logic       tick;
    logic       tick_en;
    logic       value_zero;

    assign value_zero = (min_q == 6'd0) && (sec_q == 6'd0);
    assign tick_en    = (state_q == ST_RUN);

    cntdown_tick u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .clr  (load | start_idle),
        .num  (num),
        .tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        min_d       = min_q;
        sec_d       = sec_q;
        saved_min_d = saved_min_q;
        saved_sec_d = saved_sec_q;
        done_d      = 1'b0;
        start_idle  = 1'b0;
        if (load) begin
            min_d       = sat6(load_min, MIN_MAX);
            sec_d       = sat6(load_sec, SEC_MAX);
            saved_min_d = sat6(load_min, MIN_MAX);
            saved_sec_d = sat6(load_sec, SEC_MAX);
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !value_zero) begin
                        state_d    = ST_RUN;
                        start_idle = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        if (sec_q != 6'd0) begin
                            sec_d = sec_q - 6'd1;
                            if ((min_q == 6'd0) && (sec_q == 6'd1)) begin
                                done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                                if ((saved_min_q == 6'd0) && (saved_sec_q == 6'd0)) begin
                                    state_d = ST_DONE;
                                end
`else
                                state_d = ST_DONE;
`endif
                            end
                        end else if (min_q != 6'd0) begin
                            min_d = min_q - 6'd1;
                            sec_d = SEC_MAX;
                        end else begin
                            // 00:00 while running: one full period shown before restarting
`ifdef AUTO_RELOAD_EN
                            min_d = saved_min_q;
                            sec_d = saved_sec_q;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end
                    if (pause && (state_d == ST_RUN)) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            min_q       <= 6'd0;
            sec_q       <= 6'd0;
            saved_min_q <= 6'd0;
            saved_sec_q <= 6'd0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            saved_min_q <= saved_min_d;
            saved_sec_q <= saved_sec_d;
            running_q   <= running_d;
            done_q      <= done_d;
        end
    end

    assign min     = min_q;
    assign sec     = sec_q;
    assign running = running_q;
    assign done    = done_q;

endmodule
